// File: rtl/stopwatch_if.sv
// Button, counter-chain and display signals of the stopwatch sequencer.
// The slave side is the controller; the master side is its environment.
interface stopwatch_if;
    logic        btn_ss;
    logic        btn_lap;
    logic        btn_clr;
    logic [11:0] cnt_value;
    logic        cnt_en;
    logic        cnt_clr_n;
    logic [11:0] disp_value;
    logic        running;
    logic        lap_active;
    logic        ovf;

    modport master (
        output btn_ss, btn_lap, btn_clr, cnt_value,
        input  cnt_en, cnt_clr_n, disp_value,
        input  running, lap_active, ovf
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, cnt_value,
        output cnt_en, cnt_clr_n, disp_value,
        output running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button pulses -> gated count tick, counter clear
// and a lap snapshot for the display path.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter logic [3:0]  MAX0        = 4'd9,
    parameter logic [3:0]  MAX1        = 4'd9,
    parameter logic [3:0]  MAX2        = 4'd9,
    parameter bit          STOP_AT_MAX = 1'b1
) (
    input logic        clk,
    input logic        reset,
    stopwatch_if.slave sw
);
    localparam int unsigned   PW  = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, RUN, STOP, LAP, OVF
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [11:0]   lap_reg;
    logic [11:0]   disp_q;
    logic          en_q;
    logic          clr_n_q;
    logic          counting;
    logic          tick_due;
    logic          at_max;
    logic          ss_stop;
    logic          ovf_hit;
    logic          issue;
    logic          lap_take;
    logic          run_o;
    logic          lap_o;
    logic          ovf_o;

    // A stop press swallows a tick that falls due in the same cycle.
    always_comb begin
        counting = (state == RUN) || (state == LAP);
        tick_due = counting && (presc == TOP);
        at_max   = sw.cnt_value == {MAX2, MAX1, MAX0};
        ss_stop  = counting && sw.btn_ss;
        ovf_hit  = tick_due && at_max && STOP_AT_MAX
                   && !ss_stop;
        issue    = tick_due && !sw.btn_clr && !ss_stop
                   && !(at_max && STOP_AT_MAX);
        lap_take = counting && sw.btn_lap && !sw.btn_ss
                   && !ovf_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sw.btn_clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (sw.btn_ss) state_nxt = RUN;
                STOP: if (sw.btn_ss) state_nxt = RUN;
                RUN, LAP: begin
                    if (ss_stop)       state_nxt = STOP;
                    else if (ovf_hit)  state_nxt = OVF;
                    else if (lap_take) state_nxt = LAP;
                end
                OVF:     state_nxt = OVF;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        run_o = 1'b0;
        lap_o = 1'b0;
        ovf_o = 1'b0;
        case (state)
            RUN: run_o = 1'b1;
            LAP: begin
                run_o = 1'b1;
                lap_o = 1'b1;
            end
            OVF:     ovf_o = 1'b1;
            default: ;
        endcase
    end

    // Prescaler holds its phase across STOP so resume is seamless.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            lap_reg <= '0;
            en_q    <= 1'b0;
            clr_n_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            clr_n_q <= !sw.btn_clr;
            en_q    <= issue;
            disp_q  <= (state == LAP) ? lap_reg : sw.cnt_value;
            if (sw.btn_clr) begin
                presc   <= '0;
                lap_reg <= '0;
            end else begin
                if (state == IDLE && sw.btn_ss)
                    presc <= '0;
                else if (counting)
                    presc <= (presc == TOP) ? '0 : presc + 1'b1;
                if (lap_take)
                    lap_reg <= sw.cnt_value;
            end
        end
    end

    assign sw.cnt_en     = en_q;
    assign sw.cnt_clr_n  = clr_n_q;
    assign sw.disp_value = disp_q;
    assign sw.running    = run_o;
    assign sw.lap_active = lap_o;
    assign sw.ovf        = ovf_o;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (freeze and wrap at max)
// against an abstract model, plus hand-computed directed expectations.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int MI = 0, MR = 1, MS = 2, ML = 3, MO = 4;

    typedef struct {
        int          mode;
        int          phase;
        logic [11:0] lap;
        logic        en;
        logic        clr_n;
        logic [11:0] disp;
    } mdl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;
    logic [11:0] cnt_value = '0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_on = 0;
    mdl_t        m0;
    mdl_t        m1;

    stopwatch_if i0();
    stopwatch_if i1();

    assign i0.btn_ss    = btn_ss;
    assign i0.btn_lap   = btn_lap;
    assign i0.btn_clr   = btn_clr;
    assign i0.cnt_value = cnt_value;
    assign i1.btn_ss    = btn_ss;
    assign i1.btn_lap   = btn_lap;
    assign i1.btn_clr   = btn_clr;
    assign i1.cnt_value = cnt_value;

    stopwatch_ctrl #(.TICK_DIV(TD), .STOP_AT_MAX(1'b1)) dut0 (
        .clk(clk), .reset(reset), .sw(i0)
    );
    stopwatch_ctrl #(.TICK_DIV(TD), .STOP_AT_MAX(1'b0)) dut1 (
        .clk(clk), .reset(reset), .sw(i1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Outputs derived from the model's mode and cycle accounting.
    function automatic mdl_t step(mdl_t s, logic r, logic c,
                                  logic ss, logic lp,
                                  logic [11:0] v, bit sam);
        mdl_t n = s;
        bit live, due, full;
        if (r) begin
            n.mode = MI; n.phase = 0; n.lap = '0;
            n.en = 0; n.clr_n = 0; n.disp = '0;
            return n;
        end
        live = (s.mode == MR) || (s.mode == ML);
        due  = live && (s.phase == TD - 1);
        full = (v == 12'h999);
        n.disp  = (s.mode == ML) ? s.lap : v;
        n.clr_n = !c;
        n.en    = 0;
        if (c) begin
            n.mode = MI; n.phase = 0; n.lap = '0;
            return n;
        end
        if (live) n.phase = (s.phase + 1) % TD;
        if (s.mode == MI && ss) begin
            n.mode = MR; n.phase = 0;
        end else if (s.mode == MS && ss) begin
            n.mode = MR;
        end else if (live) begin
            if (ss) n.mode = MS;
            else begin
                n.en = due && !(full && sam);
                if (due && full && sam) n.mode = MO;
                else if (lp) begin
                    n.lap = v; n.mode = ML;
                end
            end
        end
        return n;
    endfunction

    task automatic cmp(input string t, input mdl_t m,
                       input logic en, input logic cn,
                       input logic [11:0] dv, input logic rn,
                       input logic la, input logic ov);
        chk({t, ".cnt_en"}, en, m.en);
        chk({t, ".cnt_clr_n"}, cn, m.clr_n);
        chk({t, ".disp"}, dv, m.disp);
        chk({t, ".running"}, rn, m.mode == MR || m.mode == ML);
        chk({t, ".lap_active"}, la, m.mode == ML);
        chk({t, ".ovf"}, ov, m.mode == MO);
    endtask

    always @(posedge clk) begin
        m0 = step(m0, reset, btn_clr, btn_ss, btn_lap, cnt_value, 1'b1);
        m1 = step(m1, reset, btn_clr, btn_ss, btn_lap, cnt_value, 1'b0);
        if (reset) chk_on = 1;
        #1;
        if (chk_on) begin
            cmp("m0", m0, i0.cnt_en, i0.cnt_clr_n, i0.disp_value,
                i0.running, i0.lap_active, i0.ovf);
            cmp("m1", m1, i1.cnt_en, i1.cnt_clr_n, i1.disp_value,
                i1.running, i1.lap_active, i1.ovf);
        end
    end

    task automatic pss();
        btn_ss = 1; @(negedge clk); btn_ss = 0;
    endtask
    task automatic plap();
        btn_lap = 1; @(negedge clk); btn_lap = 0;
    endtask
    task automatic pclr();
        btn_clr = 1; @(negedge clk); btn_clr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1;
        @(negedge clk);
        chk("rst.clr_n", i0.cnt_clr_n, 0);
        chk("rst.en", i0.cnt_en, 0);
        chk("rst.disp", i0.disp_value, 0);
        chk("rst.running", i0.running, 0);
        reset = 0;
        @(negedge clk);
        chk("rst.clr_n_rel", i0.cnt_clr_n, 1);

        // 1: ten ticks in forty clocks
        pss();
        n0 = 0; n1 = 0;
        repeat (40) begin
            @(negedge clk);
            if (i0.cnt_en) n0++;
            if (i1.cnt_en) n1++;
        end
        chk("t1.ticks0", 12'(n0), 10);
        chk("t1.ticks1", 12'(n1), 10);
        chk("t1.running", i0.running, 1);

        // 2: stop at phase 2, resume two clocks from tick
        repeat (2) @(negedge clk);
        pss();
        n0 = 0;
        repeat (20) begin
            @(negedge clk);
            if (i0.cnt_en) n0++;
        end
        chk("t2.stopped_ticks", 12'(n0), 0);
        chk("t2.running", i0.running, 0);
        pss();
        chk("t2.resume_en0", i0.cnt_en, 0);
        @(negedge clk);
        chk("t2.resume_en1", i0.cnt_en, 1);

        // 3: lap snapshots
        cnt_value = 12'h042;
        plap();
        chk("t3.lap_active", i0.lap_active, 1);
        cnt_value = 12'h043;
        @(negedge clk);
        chk("t3.disp042", i0.disp_value, 12'h042);
        cnt_value = 12'h057;
        @(negedge clk);
        chk("t3.disp042b", i0.disp_value, 12'h042);
        plap();
        cnt_value = 12'h058;
        @(negedge clk);
        chk("t3.disp057", i0.disp_value, 12'h057);
        pss();
        chk("t3.stop_running", i0.running, 0);
        @(negedge clk);
        chk("t3.disp_live", i0.disp_value, 12'h058);
        chk("t3.lap_off", i0.lap_active, 0);

        // 4: freeze at 999 vs wrap
        cnt_value = 12'h999;
        pss();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (i0.cnt_en) n0++;
            if (i1.cnt_en) n1++;
            if (i0.ovf) break;
        end
        chk("t4.ovf", i0.ovf, 1);
        chk("t4.no_tick", 12'(n0), 0);
        chk("t4.wrap_tick", 12'(n1), 1);
        chk("t4.wrap_running", i1.running, 1);
        pss();
        chk("t4.ss_ignored", i0.ovf, 1);
        pclr();
        chk("t4.clr_n", i0.cnt_clr_n, 0);
        chk("t4.ovf_off", i0.ovf, 0);
        @(negedge clk);
        chk("t4.clr_n_rel", i0.cnt_clr_n, 1);

        // 5: clear beats start/stop
        cnt_value = 12'h000;
        pss();
        repeat (3) @(negedge clk);
        btn_clr = 1; btn_ss = 1;
        @(negedge clk);
        btn_clr = 0; btn_ss = 0;
        chk("t5.clr_n", i0.cnt_clr_n, 0);
        chk("t5.running", i0.running, 0);
        chk("t5.en", i0.cnt_en, 0);
        @(negedge clk);
        chk("t5.clr_n_rel", i0.cnt_clr_n, 1);
        chk("t5.idle", i0.running, 0);

        // 6: reset mid-lap
        cnt_value = 12'h123;
        pss();
        plap();
        repeat (2) @(negedge clk);
        chk("t6.lap_active", i0.lap_active, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t6.clr_n", i0.cnt_clr_n, 0);
        chk("t6.en", i0.cnt_en, 0);
        chk("t6.disp", i0.disp_value, 0);
        chk("t6.running", i0.running, 0);
        chk("t6.lap", i0.lap_active, 0);
        chk("t6.ovf", i0.ovf, 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
